// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with valid/ready output, framing-error and overrun flags.
// Define UART_RX_PARITY_EN to add a parity bit after the data bits and check it.
module uart_rx_param #(
    parameter int unsigned CLKS_PER_BIT = 104,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned PARITY_ODD   = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_Rx_Serial,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic                 o_frame_err,
    output logic                 o_par_err,
    output logic                 o_overrun,
    output logic                 o_busy
);
    localparam int unsigned CntW = 16;
    localparam logic [CntW-1:0] Mid      = CntW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CntW-1:0] Last     = CntW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]      LastData = 4'(DATA_BITS - 1);
    localparam logic [3:0]      LastStop = 4'(STOP_BITS - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop, StDone, StBreak} state_e;
`else
    typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StDone, StBreak} state_e;
`endif

    state_e                 state_q, state_d;
    logic                   rx_meta_q, rx_sync_q;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic [3:0]             idx_q, idx_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   stop_ok_q, stop_ok_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   frame_err_q, frame_err_d;
    logic                   par_err_q, par_err_d;
    logic                   overrun_q, overrun_d;
    logic                   wrap;
    logic                   par_fail;

`ifdef UART_RX_PARITY_EN
    localparam logic ParOdd = 1'(PARITY_ODD);
    logic par_bit_q, par_bit_d;
    assign par_fail = ((^shift_q) ^ par_bit_q) != ParOdd;
`else
    assign par_fail = 1'b0;
`endif

    assign wrap = (cnt_q == Last);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta_q   <= 1'b1;
            rx_sync_q   <= 1'b1;
            state_q     <= StIdle;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            stop_ok_q   <= 1'b1;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            par_err_q   <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit_q   <= 1'b0;
`endif
        end else begin
            rx_meta_q   <= i_Rx_Serial;
            rx_sync_q   <= rx_meta_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            stop_ok_q   <= stop_ok_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            par_err_q   <= par_err_d;
            overrun_q   <= overrun_d;
`ifdef UART_RX_PARITY_EN
            par_bit_q   <= par_bit_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        stop_ok_d   = stop_ok_q;
        data_d      = data_q;
        valid_d     = valid_q & ~i_ready;
        frame_err_d = 1'b0;
        par_err_d   = 1'b0;
        overrun_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bit_d   = par_bit_q;
`endif
        unique case (state_q)
            StIdle: begin
                cnt_d     = '0;
                idx_d     = '0;
                stop_ok_d = 1'b1;
                if (!rx_sync_q) state_d = StStart;
            end
            StStart: begin
                // Leaving at mid start bit puts every later wrap at mid-bit.
                if (cnt_q == Mid) begin
                    cnt_d   = '0;
                    state_d = rx_sync_q ? StIdle : StData;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StData: begin
                if (wrap) begin
                    cnt_d   = '0;
                    shift_d = {rx_sync_q, shift_q[DATA_BITS-1:1]};
                    idx_d   = idx_q + 4'd1;
                    if (idx_q == LastData) begin
                        idx_d = '0;
`ifdef UART_RX_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
`ifdef UART_RX_PARITY_EN
            StParity: begin
                if (wrap) begin
                    cnt_d     = '0;
                    par_bit_d = rx_sync_q;
                    state_d   = StStop;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
`endif
            StStop: begin
                if (wrap) begin
                    cnt_d     = '0;
                    stop_ok_d = stop_ok_q & rx_sync_q;
                    idx_d     = idx_q + 4'd1;
                    if (idx_q == LastStop) begin
                        idx_d   = '0;
                        state_d = StDone;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StDone: begin
                state_d = rx_sync_q ? StIdle : StBreak;
                if (!stop_ok_q) begin
                    frame_err_d = 1'b1;
                end else if (par_fail) begin
                    par_err_d = 1'b1;
                end else if (valid_q && !i_ready) begin
                    overrun_d = 1'b1;
                end else begin
                    data_d  = shift_q;
                    valid_d = 1'b1;
                end
            end
            StBreak: begin
                if (rx_sync_q) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign o_data      = data_q;
    assign o_valid     = valid_q;
    assign o_frame_err = frame_err_q;
    assign o_par_err   = par_err_q;
    assign o_overrun   = overrun_q;
    assign o_busy      = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_param.sv
// Self-checking bench for uart_rx_param: directed scenarios plus random frames checked
// against an event-queue model of what each transmitted frame must produce.
`timescale 1ns/1ps
module tb_uart_rx_param;
    localparam int unsigned CPB  = 16;
    localparam int unsigned DW   = 8;
    localparam int unsigned SB   = 1;
    localparam int unsigned PODD = 0;
    localparam int KWord = 0;
    localparam int KFe   = 1;
    localparam int KPe   = 2;
    localparam int KOv   = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          rx = 1'b1;
    logic          i_ready = 1'b1;
    logic [DW-1:0] o_data;
    logic          o_valid, o_frame_err, o_par_err, o_overrun, o_busy;

    always #5 clk = ~clk;

    uart_rx_param #(
        .CLKS_PER_BIT(CPB),
        .DATA_BITS   (DW),
        .STOP_BITS   (SB),
        .PARITY_ODD  (PODD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_Rx_Serial(rx),
        .o_data     (o_data),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_frame_err(o_frame_err),
        .o_par_err  (o_par_err),
        .o_overrun  (o_overrun),
        .o_busy     (o_busy)
    );

    typedef struct {
        int            kind;
        logic [DW-1:0] data;
    } ev_t;

    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_pass = 0;
    int  n_valid_cyc = 0, n_fe = 0, n_pe = 0, n_ov = 0, n_words = 0;
    bit  held = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic fail(input string name, input string msg);
        n_checks++;
        $display("FAIL %s: %s", name, msg);
    endtask

    // Model: each frame yields exactly one outcome, decided from the frame contents.
    task automatic expect_frame(input logic [DW-1:0] d, input bit stop_bad, input bit par_bad);
        ev_t e;
        e.data = d;
        if (stop_bad)                e.kind = KFe;
        else if (par_bad)            e.kind = KPe;
        else if (held && !i_ready)   e.kind = KOv;
        else begin
            e.kind = KWord;
            held   = !i_ready;
        end
        exp_q.push_back(e);
    endtask

    task automatic bit_time(input logic v);
        rx = v;
        repeat (CPB) @(posedge clk);
    endtask

    task automatic idle_bits(input int n);
        for (int i = 0; i < n; i++) bit_time(1'b1);
    endtask

    // stop_low > 0 leaves the line low after that many bit times of low stop.
    task automatic send(input logic [DW-1:0] d, input bit par_bad, input int stop_low);
        logic odd;
        odd = PODD[0];
        expect_frame(d, stop_low > 0, par_bad);
        bit_time(1'b0);
        for (int i = 0; i < DW; i++) bit_time(d[i]);
`ifdef UART_RX_PARITY_EN
        bit_time((^d) ^ odd ^ par_bad);
`else
        if (odd && par_bad) rx = 1'b1;
`endif
        if (stop_low > 0) begin
            for (int i = 0; i < stop_low; i++) bit_time(1'b0);
        end else begin
            for (int i = 0; i < SB; i++) bit_time(1'b1);
        end
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 40 * CPB) begin
            @(posedge clk);
            t++;
        end
        if (exp_q.size() != 0) fail("drain", $sformatf("%0d expected events never seen", exp_q.size()));
    endtask

    task automatic pop_expect(input int kind, input string name);
        ev_t e;
        if (exp_q.size() == 0) begin
            fail(name, $sformatf("unexpected event kind %0d, none expected", kind));
        end else begin
            e = exp_q.pop_front();
            chk(name, kind, e.kind);
            if (kind == KWord && e.kind == KWord) chk("word_data", o_data, e.data);
        end
    endtask

    logic          pv = 1'b0, phs = 1'b0, pfe = 1'b0, ppe = 1'b0, pov = 1'b0;
    logic [DW-1:0] pdata = '0;

    always @(negedge clk) begin : monitor
        if (rst) begin
            if (o_valid) n_valid_cyc++;
            if (o_valid && (!pv || phs)) begin
                n_words++;
                pop_expect(KWord, "word_kind");
            end else if (o_valid && pv) begin
                chk("data_stable", o_data, pdata);
            end
            if (o_frame_err) begin
                n_fe++;
                chk("fe_width", pfe, 0);
                pop_expect(KFe, "frame_err_kind");
            end
            if (o_par_err) begin
                n_pe++;
                chk("pe_width", ppe, 0);
                pop_expect(KPe, "par_err_kind");
            end
            if (o_overrun) begin
                n_ov++;
                chk("ov_width", pov, 0);
                pop_expect(KOv, "overrun_kind");
            end
            pv    = o_valid;
            phs   = o_valid & i_ready;
            pdata = o_data;
            pfe   = o_frame_err;
            ppe   = o_par_err;
            pov   = o_overrun;
        end else begin
            pv  = 1'b0;
            phs = 1'b0;
            pfe = 1'b0;
            ppe = 1'b0;
            pov = 1'b0;
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_data"}, o_data, 0);
        chk({tag, "_valid"}, o_valid, 0);
        chk({tag, "_busy"}, o_busy, 0);
        chk({tag, "_fe"}, o_frame_err, 0);
        chk({tag, "_pe"}, o_par_err, 0);
        chk({tag, "_ov"}, o_overrun, 0);
    endtask

    initial begin
        int v0, fe0, pe0, ov0, w0;
        int stop_low;
        int r;
        bit par_bad;
        logic [DW-1:0] d;

        repeat (3) @(posedge clk);
        #1 chk_all_zero("reset");
        @(posedge clk);
        rst = 1'b1;
        idle_bits(2);

        // 1: single word with consumer ready
        v0 = n_valid_cyc; fe0 = n_fe; pe0 = n_pe; ov0 = n_ov;
        send(8'hA5, 1'b0, 0);
        idle_bits(2);
        drain();
        chk("t1_valid_cycles", n_valid_cyc - v0, 1);
        chk("t1_data", o_data, 8'hA5);
        chk("t1_errors", (n_fe - fe0) + (n_pe - pe0) + (n_ov - ov0), 0);

        // 2: overrun while consumer stalls
        @(posedge clk);
        i_ready = 1'b0;
        ov0 = n_ov;
        send(8'h3C, 1'b0, 0);
        send(8'hC3, 1'b0, 0);
        idle_bits(2);
        drain();
        #1;
        chk("t2_valid_held", o_valid, 1);
        chk("t2_data_kept", o_data, 8'h3C);
        chk("t2_overruns", n_ov - ov0, 1);
        @(posedge clk);
        i_ready = 1'b1;
        held    = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk("t2_valid_dropped", o_valid, 0);

        // 3: stop bit held low for three bit times
        fe0 = n_fe; w0 = n_words;
        send(8'h55, 1'b0, 3);
        #1;
        chk("t3_busy_in_break", o_busy, 1);
        chk("t3_valid", o_valid, 0);
        chk("t3_frame_errs", n_fe - fe0, 1);
        chk("t3_no_word", n_words - w0, 0);
        rx = 1'b1;
        repeat (5) @(posedge clk);
        #1 chk("t3_busy_released", o_busy, 0);
        idle_bits(2);

        // 4: 5-clock low glitch on an idle line
        w0 = n_words; fe0 = n_fe; pe0 = n_pe; ov0 = n_ov;
        rx = 1'b0;
        repeat (4) @(posedge clk);
        #1 chk("t4_busy_start", o_busy, 1);
        @(posedge clk);
        rx = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        chk("t4_busy_idle", o_busy, 0);
        chk("t4_no_events", (n_words - w0) + (n_fe - fe0) + (n_pe - pe0) + (n_ov - ov0), 0);
        chk("t4_data_kept", o_data, 8'h3C);

`ifdef UART_RX_PARITY_EN
        // 5: even parity accept and reject
        pe0 = n_pe;
        send(8'h07, 1'b0, 0);
        idle_bits(2);
        drain();
        chk("t5_data", o_data, 8'h07);
        chk("t5_no_par_err", n_pe - pe0, 0);
        send(8'h07, 1'b1, 0);
        idle_bits(2);
        drain();
        #1;
        chk("t5_par_errs", n_pe - pe0, 1);
        chk("t5_valid", o_valid, 0);
`endif

        // Random frames, some with bad stop (and bad parity when enabled)
        for (int k = 0; k < 24; k++) begin
            d        = DW'($urandom);
            r        = int'($urandom_range(0, 9));
            stop_low = (r == 0) ? int'($urandom_range(1, 3)) : 0;
            par_bad  = 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad  = (r == 1);
`endif
            send(d, par_bad, stop_low);
            if (stop_low > 0) idle_bits(1);
            idle_bits(int'($urandom_range(0, 2)));
        end
        idle_bits(2);
        drain();

        // 6: reset in the middle of a frame of 0xFF
        send(8'h5A, 1'b0, 0);
        idle_bits(2);
        drain();
        bit_time(1'b0);
        bit_time(1'b1);
        bit_time(1'b1);
        bit_time(1'b1);
        repeat (5) @(posedge clk);
        #1 chk("t6_busy_before", o_busy, 1);
        rst = 1'b0;
        #1 chk_all_zero("t6_reset");
        rx = 1'b1;
        repeat (3) @(posedge clk);
        rst = 1'b1;
        idle_bits(2);
        send(8'h12, 1'b0, 0);
        idle_bits(2);
        drain();
        chk("t6_data", o_data, 8'h12);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #20ms;
        $display("FAIL global_timeout: simulation did not finish, %0d checks so far", n_checks);
        $fatal(1);
    end
endmodule
